// File: rtl/console_pkg.sv
// Shared constants and types for the console transmitter.
package console_pkg;

  // Default store address that targets the console.
  localparam logic [31:0] STDOUT_ADDR = 32'h8000_0004;

  // Transmit FSM: IDLE waits for a buffered word, SEND streams its bytes.
  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock word FIFO. Empty/full derive from the registered level,
// never from pointer equality; pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [LVL_W-1:0] level,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (level_q == LVL_W'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Next pointers and level; simultaneous push and pop keep the level.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // Pointer and level registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/console_tx.sv
// Console transmitter: buffers 32-bit stores to the console address and
// sends each word as four bytes, most-significant byte first.
//
// Byte handshake: tx_valid/tx_data are registered. A byte transfers on a
// clock edge where tx_valid && tx_ready. Once tx_valid is high it stays
// high, with tx_data stable, until that transfer (only rst can drop it).
module console_tx
  import console_pkg::*;
#(
  parameter logic [31:0] STDOUT = STDOUT_ADDR,
  parameter int          DEPTH  = 8,
  localparam int         LVL_W  = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [31:0]      wr_addr,
  input  logic [31:0]      wr_data,
  output logic             full,
  output logic [LVL_W-1:0] level,
  output logic             overflow,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready
);

  tx_state_t   state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] sh_q, sh_d;
  logic        overflow_q, overflow_d;

  logic        hit;
  logic        fifo_pop;
  logic [31:0] fifo_rdata;
  logic        fifo_full;
  logic        fifo_empty;

  // Console store decode; the FIFO itself refuses pushes while full.
  assign hit = wr_en && (wr_addr == STDOUT);

  sync_fifo #(
    .WIDTH(32),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (hit),
    .wdata(wr_data),
    .pop  (fifo_pop),
    .rdata(fifo_rdata),
    .level(level),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign full     = fifo_full;
  assign overflow = overflow_q;
  assign tx_valid = (state_q == SEND);
  assign tx_data  = sh_q[31:24];

  // A store that finds the FIFO full is dropped and latched as overflow.
  always_comb begin
    overflow_d = overflow_q | (hit && fifo_full);
  end

  // Transmit FSM: load words from the FIFO, shift out bytes on handshake,
  // and chain directly into the next word with no idle cycle.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    sh_d     = sh_q;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          sh_d     = fifo_rdata;
          idx_d    = 2'd0;
          state_d  = SEND;
        end
      end
      SEND: begin
        if (tx_ready) begin
          if (idx_q != 2'd3) begin
            sh_d  = {sh_q[23:0], 8'h00};
            idx_d = idx_q + 2'd1;
          end else if (!fifo_empty) begin
            fifo_pop = 1'b1;
            sh_d     = fifo_rdata;
            idx_d    = 2'd0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM, shifter and overflow registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= 2'd0;
      sh_q       <= 32'h0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      sh_q       <= sh_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_console_tx.sv
// Bench for console_tx: table-driven single-word / back-to-back vectors
// plus hand-written reset, backpressure, overflow and mid-word reset runs.
module tb_console_tx;

  localparam logic [31:0] S_ADDR = 32'h8000_0004;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        full;
  logic [3:0]  level;
  logic        overflow;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];

  typedef struct {
    logic        wr_en;
    logic [31:0] addr;
    logic [31:0] data;
    logic        ready;
    logic        exp_valid;
    logic [7:0]  exp_data;
    logic [3:0]  exp_level;
    logic        exp_full;
  } vec_t;

  vec_t vecs[18];

  console_tx #(
    .STDOUT(S_ADDR),
    .DEPTH (8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .full    (full),
    .level   (level),
    .overflow(overflow),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready)
  );

  // Clock and reset defaults
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data);
    wr_en   = 1'b1;
    wr_addr = addr;
    wr_data = data;
  endtask

  task automatic idle_bus();
    wr_en   = 1'b0;
    wr_addr = 32'h0;
    wr_data = 32'h0;
  endtask

  function automatic vec_t mk(input logic we, input logic [31:0] a, input logic [31:0] d,
                              input logic v, input logic [7:0] b, input logic [3:0] l);
    vec_t r;
    r.wr_en     = we;
    r.addr      = a;
    r.data      = d;
    r.ready     = 1'b1;
    r.exp_valid = v;
    r.exp_data  = b;
    r.exp_level = l;
    r.exp_full  = 1'b0;
    return r;
  endfunction

  function automatic logic [31:0] ovf_word(input int i);
    logic [7:0] k;
    k = 8'(i);
    return {8'h10 + k, 8'h20 + k, 8'h30 + k, 8'h40 + k};
  endfunction

  initial begin
    logic [31:0] word;
    int          nbytes;
    int          cyc;

    // Single word, other-address store, back-to-back words (tx_ready = 1).
    // Expected values are the outputs just after the edge that applied the row.
    vecs[0]  = mk(1'b1, S_ADDR,        32'hDEADBEEF, 1'b0, 8'h00, 4'd1);
    vecs[1]  = mk(1'b0, 32'h0,         32'h0,        1'b1, 8'hDE, 4'd0);
    vecs[2]  = mk(1'b0, 32'h0,         32'h0,        1'b1, 8'hAD, 4'd0);
    vecs[3]  = mk(1'b0, 32'h0,         32'h0,        1'b1, 8'hBE, 4'd0);
    vecs[4]  = mk(1'b0, 32'h0,         32'h0,        1'b1, 8'hEF, 4'd0);
    vecs[5]  = mk(1'b0, 32'h0,         32'h0,        1'b0, 8'h00, 4'd0);
    vecs[6]  = mk(1'b1, 32'h8000_0000, 32'h12345678, 1'b0, 8'h00, 4'd0);
    vecs[7]  = mk(1'b0, 32'h0,         32'h0,        1'b0, 8'h00, 4'd0);
    vecs[8]  = mk(1'b1, S_ADDR,        32'h01020304, 1'b0, 8'h00, 4'd1);
    vecs[9]  = mk(1'b1, S_ADDR,        32'h05060708, 1'b1, 8'h01, 4'd1);
    vecs[10] = mk(1'b0, 32'h0,         32'h0,        1'b1, 8'h02, 4'd1);
    vecs[11] = mk(1'b0, 32'h0,         32'h0,        1'b1, 8'h03, 4'd1);
    vecs[12] = mk(1'b0, 32'h0,         32'h0,        1'b1, 8'h04, 4'd1);
    vecs[13] = mk(1'b0, 32'h0,         32'h0,        1'b1, 8'h05, 4'd0);
    vecs[14] = mk(1'b0, 32'h0,         32'h0,        1'b1, 8'h06, 4'd0);
    vecs[15] = mk(1'b0, 32'h0,         32'h0,        1'b1, 8'h07, 4'd0);
    vecs[16] = mk(1'b0, 32'h0,         32'h0,        1'b1, 8'h08, 4'd0);
    vecs[17] = mk(1'b0, 32'h0,         32'h0,        1'b0, 8'h00, 4'd0);

    // Reset values
    rst      = 1'b1;
    tx_ready = 1'b1;
    idle_bus();
    #2;
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data",  32'(tx_data),  32'd0);
    check("rst_full",     32'(full),     32'd0);
    check("rst_level",    32'(level),    32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("idle_valid_%0d", i), 32'(tx_valid), 32'd0);
    end

    // Table-driven vectors
    for (int i = 0; i < 18; i++) begin
      wr_en    = vecs[i].wr_en;
      wr_addr  = vecs[i].addr;
      wr_data  = vecs[i].data;
      tx_ready = vecs[i].ready;
      step();
      check($sformatf("vec%0d_valid", i), 32'(tx_valid), 32'(vecs[i].exp_valid));
      if (vecs[i].exp_valid)
        check($sformatf("vec%0d_data", i), 32'(tx_data), 32'(vecs[i].exp_data));
      check($sformatf("vec%0d_level", i), 32'(level), 32'(vecs[i].exp_level));
      check($sformatf("vec%0d_full", i), 32'(full), 32'(vecs[i].exp_full));
      check($sformatf("vec%0d_ovf", i), 32'(overflow), 32'd0);
    end
    idle_bus();

    // Backpressure: first byte held for 5 cycles, then resumes in order
    tx_ready = 1'b0;
    store(S_ADDR, 32'hDEADBEEF);
    step();
    idle_bus();
    step();
    check("bp_rise_valid", 32'(tx_valid), 32'd1);
    check("bp_rise_data",  32'(tx_data),  32'hDE);
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("bp_hold_valid_%0d", i), 32'(tx_valid), 32'd1);
      check($sformatf("bp_hold_data_%0d", i),  32'(tx_data),  32'hDE);
    end
    tx_ready = 1'b1;
    step();
    check("bp_b1", 32'(tx_data), 32'hAD);
    step();
    check("bp_b2", 32'(tx_data), 32'hBE);
    step();
    check("bp_b3", 32'(tx_data), 32'hEF);
    check("bp_b3_valid", 32'(tx_valid), 32'd1);
    step();
    check("bp_end_valid", 32'(tx_valid), 32'd0);

    // Overflow: 10 stores with host stalled; word 1 in sh, 8 buffered, 10th dropped
    tx_ready = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      store(S_ADDR, ovf_word(i));
      if (i <= 9) exp_q.push_back(ovf_word(i));
      step();
      if (i == 9) begin
        check("ovf_lvl9",  32'(level),    32'd8);
        check("ovf_full9", 32'(full),     32'd1);
        check("ovf_flag9", 32'(overflow), 32'd0);
      end
    end
    idle_bus();
    check("ovf_level",    32'(level),    32'd8);
    check("ovf_full",     32'(full),     32'd1);
    check("ovf_overflow", 32'(overflow), 32'd1);
    check("ovf_valid",    32'(tx_valid), 32'd1);
    check("ovf_head",     32'(tx_data),  32'h11);

    // Drain and compare assembled words against the expected queue
    tx_ready = 1'b1;
    word     = 32'h0;
    nbytes   = 0;
    cyc      = 0;
    while (exp_q.size() > 0 && cyc < 200) begin
      if (tx_valid) begin
        word = {word[23:0], tx_data};
        nbytes++;
      end
      step();
      cyc++;
      if (nbytes == 4) begin
        check($sformatf("drain_word_%0d", 9 - exp_q.size() + 1), word, exp_q.pop_front());
        nbytes = 0;
      end
    end
    check("drain_remaining", 32'(exp_q.size()), 32'd0);
    check("drain_end_valid", 32'(tx_valid), 32'd0);
    check("drain_end_level", 32'(level),    32'd0);
    check("drain_end_full",  32'(full),     32'd0);
    check("drain_ovf_sticky", 32'(overflow), 32'd1);

    // Reset mid-word: after the second byte, rst drops tx_valid at once
    tx_ready = 1'b1;
    store(S_ADDR, 32'h11223344);
    step();
    store(S_ADDR, 32'h55667788);
    step();
    idle_bus();
    check("mid_b0", 32'(tx_data), 32'h11);
    step();
    check("mid_b1", 32'(tx_data), 32'h22);
    step();
    check("mid_b2", 32'(tx_data), 32'h33);
    rst = 1'b1;
    #1;
    check("mid_rst_valid",    32'(tx_valid), 32'd0);
    check("mid_rst_data",     32'(tx_data),  32'd0);
    check("mid_rst_level",    32'(level),    32'd0);
    check("mid_rst_overflow", 32'(overflow), 32'd0);
    step();
    rst = 1'b0;
    step();
    check("post_rst_valid", 32'(tx_valid), 32'd0);
    store(S_ADDR, 32'hA1B2C3D4);
    step();
    idle_bus();
    check("post_rst_lvl", 32'(level), 32'd1);
    step();
    check("post_rst_valid1", 32'(tx_valid), 32'd1);
    check("post_rst_first",  32'(tx_data),  32'hA1);
    step();
    check("post_rst_second", 32'(tx_data), 32'hB2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/console_tx.md
# console_tx

Memory-mapped console transmitter: the output direction of the host console link. The CPU stores 32-bit words to the `STDOUT` address. The block buffers them in a word FIFO and emits each word as four bytes, most-significant first, over a byte valid/ready handshake toward the simulation host. It sits beside the data-memory decoder in `Driver` and is the counterpart of the host-side stdin path.

## Interface

Parameters:
- `STDOUT`, `32'h8000_0004`: store address that targets the console.
- `DEPTH`, `8`: FIFO depth in words; a power of two, at least 2.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset. One clock domain; reset is asynchronous and active-high.
- `wr_en`  in  1  CPU store strobe, one cycle per store.
- `wr_addr`  in  32  store address.
- `wr_data`  in  32  store data.
- `full`  out  1  FIFO holds `DEPTH` words.
- `level`  out  `$clog2(DEPTH+1)`  words currently in the FIFO. The word in the shift register is not counted.
- `overflow`  out  1  sticky; a console store was dropped.
- `tx_data`  out  8  byte to host.
- `tx_valid`  out  1  `tx_data` is valid.
- `tx_ready`  in  1  host accepts the byte.

## Operation

- **Push:** `wr_en && wr_addr == STDOUT && !full` writes `wr_data` into the FIFO tail at the clock edge. Stores to other addresses are ignored.
- **Drop:** `wr_en && wr_addr == STDOUT && full` does not write. `overflow` goes to 1 and stays there until `rst`.
- **Registered `full`:** `full` comes from the registered level. A store in the same cycle as a pop while full is still dropped.
- **FSM `tx_state_t`:** two states, `IDLE` and `SEND`, plus a 2-bit byte index `idx` and a 32-bit shift register `sh`.
  - `IDLE`, FIFO non-empty: pop the head into `sh`, set `idx` to 0, go to `SEND`.
  - `SEND`: `tx_valid` = 1 and `tx_data` = `sh[31:24]`.
  - `SEND`, handshake (`tx_valid && tx_ready`) with `idx` < 3: shift `sh` left by 8 and increment `idx`.
  - `SEND`, handshake with `idx` == 3 and FIFO non-empty: pop the next word into `sh`, set `idx` to 0, stay in `SEND`. There is no bubble between words.
  - `SEND`, handshake with `idx` == 3 and FIFO empty: go to `IDLE`.
- **Hold:** while `tx_valid && !tx_ready`, `tx_data`, `idx` and `sh` are held stable.
- **Simultaneous push and pop:** when not full, both happen and `level` is unchanged. When `level` is 0, a push in that cycle cannot be popped until the next cycle.
- **FIFO pointers:** `$clog2(DEPTH)` bits wide and wrap naturally. Empty/full are derived from `level`, not from pointer equality.
- **Reset values:** `tx_valid` 0, `tx_data` 0, `full` 0, `level` 0, `overflow` 0, state `IDLE`, `idx` 0, `sh` 0, both pointers 0.
- **Reset mid-operation:** `rst` asserted at any time clears everything asynchronously. `tx_valid` falls without waiting for a clock edge. A partially sent word and all buffered words are discarded.

## Timing

- **Latency:** a store accepted at edge N makes the FIFO non-empty after N. The FSM pops at edge N+1, so `tx_valid` is high from just after N+1. Latency from store to first byte is 2 cycles.
- **Throughput:** with `tx_ready` held at 1, one byte per cycle, 4 cycles per word, no idle cycle between consecutive words.
- **Handshake:** `tx_valid` never drops without a handshake, except under `rst`.
- **Outputs:** all outputs are registered. `tx_ready` has no combinational path to any output.

## Structure

- Package `console_pkg`: `STDOUT_ADDR` constant (default for `STDOUT`) and enum `tx_state_t {IDLE, SEND}`.
- Sub-module `sync_fifo`, parameterised by `WIDTH` and `DEPTH`, with push, pop, `rdata`, `level`, `full` and `empty`. `console_tx` contains the address decode, the overflow flag, the FSM and the shifter.

## Test plan

- **Reset values:** assert `rst` -> all outputs 0. Release `rst` with no stores -> `tx_valid` stays 0.
- **Single word:** with `tx_ready` = 1, store `32'hDEADBEEF` to `STDOUT` at edge 0 -> `tx_data` sequence `DE AD BE EF` on cycles 2–5, then `tx_valid` = 0. A store to `32'h8000_0000` produces nothing.
- **Backpressure:** hold `tx_ready` = 0 for 5 cycles after `tx_valid` rises -> `tx_data` = `DE` is stable throughout. Raising `tx_ready` resumes the sequence with no byte lost or duplicated.
- **Overflow:** with `tx_ready` = 0, store 10 words with `DEPTH` = 8 -> the first word sits in `sh`, `level` = 8, `full` = 1. The 10th store is dropped and `overflow` = 1. Draining yields exactly words 1–9 in order.
- **Back-to-back words:** with `tx_ready` = 1, store `32'h01020304` and `32'h05060708` on consecutive cycles -> 8 consecutive bytes `01`…`08` with `tx_valid` continuously high.
- **Reset mid-word:** assert `rst` after the second byte of a word -> `tx_valid` = 0 immediately. After release, a new store `32'hA1B2C3D4` yields `A1` first.
